// File: rtl/sseg_responder.sv
// sseg_responder: single-register bus target driving a 4-digit multiplexed
// seven-segment display. The register holds four hex digits [15:0], four
// decimal points [19:16] and a display enable [31]; all other bits are zero.
// Optional feature macro: SSEG_READBACK_EN (when defined, valid reads return
// the register contents; when undefined, valid reads return zero and no
// read-data mux is built).
module sseg_responder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000100C,
  parameter int          SCAN_DIV  = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        req_ready,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [6:0]  seg_n,
  output logic        dp_n,
  output logic [3:0]  an_n
);

  localparam logic [15:0] SCAN_LAST = 16'(SCAN_DIV - 1);

  // Register state is split into the fields that actually exist
  logic [15:0] digits_q, digits_d;
  logic [3:0]  dots_q, dots_d;
  logic        enable_q, enable_d;

  logic [15:0] scan_cnt_q, scan_cnt_d;
  logic [1:0]  index_q, index_d;

  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_err_q, rsp_err_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;

  logic [3:0]  an_n_q, an_n_d;
  logic [6:0]  seg_n_q, seg_n_d;
  logic        dp_n_q, dp_n_d;

  logic        accept;
  logic        addr_ok;
  logic [3:0]  cur_digit;
  logic        unused_wdata;

  // Register bits 30:20 do not exist, so those write-data bits are dropped
  assign unused_wdata = ^req_wdata[30:20];

  assign req_ready = !rsp_valid_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;
  assign an_n      = an_n_q;
  assign seg_n     = seg_n_q;
  assign dp_n      = dp_n_q;

  assign accept  = req_valid && !rsp_valid_q;
  assign addr_ok = (req_addr[31:2] == BASE_ADDR[31:2]) && (req_addr[1:0] == 2'b00);

  // Hex digit to active-low {g,f,e,d,c,b,a} pattern
  function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  // Register update: byte-enabled writes on accepted, correctly addressed writes
  always_comb begin
    digits_d = digits_q;
    dots_d   = dots_q;
    enable_d = enable_q;
    if (accept && req_write && addr_ok) begin
      if (req_wstrb[0]) digits_d[7:0]  = req_wdata[7:0];
      if (req_wstrb[1]) digits_d[15:8] = req_wdata[15:8];
      if (req_wstrb[2]) dots_d         = req_wdata[19:16];
      if (req_wstrb[3]) enable_d       = req_wdata[31];
    end
  end

  // Response channel: one outstanding request, held until consumed
  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    if (accept) begin
      rsp_valid_d = 1'b1;
      rsp_err_d   = !addr_ok;
`ifdef SSEG_READBACK_EN
      rsp_rdata_d = (addr_ok && !req_write) ? {enable_q, 11'b0, dots_q, digits_q} : 32'h0;
`else
      rsp_rdata_d = 32'h0;
`endif
    end else if (rsp_valid_q && rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  // Scan timing: each digit stays lit for SCAN_DIV cycles, enabled or not
  always_comb begin
    scan_cnt_d = scan_cnt_q + 16'd1;
    index_d    = index_q;
    if (scan_cnt_q == SCAN_LAST) begin
      scan_cnt_d = 16'd0;
      index_d    = index_q + 2'd1;
    end
  end

  // Display drive computed from current index/register, registered below
  always_comb begin
    cur_digit = digits_q[{index_q, 2'b00} +: 4];
    an_n_d    = 4'b1111;
    seg_n_d   = 7'b1111111;
    dp_n_d    = 1'b1;
    if (enable_q) begin
      an_n_d  = ~(4'b0001 << index_q);
      seg_n_d = hex_to_seg(cur_digit);
      dp_n_d  = ~dots_q[index_q];
    end
  end

  // All state flops; reset blanks the display and discards any response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digits_q    <= 16'h0;
      dots_q      <= 4'h0;
      enable_q    <= 1'b0;
      scan_cnt_q  <= 16'h0;
      index_q     <= 2'd0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 32'h0;
      an_n_q      <= 4'b1111;
      seg_n_q     <= 7'b1111111;
      dp_n_q      <= 1'b1;
    end else begin
      digits_q    <= digits_d;
      dots_q      <= dots_d;
      enable_q    <= enable_d;
      scan_cnt_q  <= scan_cnt_d;
      index_q     <= index_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      an_n_q      <= an_n_d;
      seg_n_q     <= seg_n_d;
      dp_n_q      <= dp_n_d;
    end
  end

endmodule
